arm_multicycle_ctrl: RTL and testbench
======================================

ARM_MULTICYCLE_CTRL -- requirements
Module: arm_multicycle_ctrl

Interface
REQ-001 Parameters: none; all encodings come from shared package arm_ctrl_pkg.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Cond  input  4  instruction condition field, bits [31:28] of the held instruction.
REQ-005 Op  input  2  instruction class: 00 data-proc, 01 memory, 10 branch, 11 illegal.
REQ-006 Funct  input  6  bits [25:20]: I-bit, cmd[3:0], S/L bit.
REQ-007 Rd  input  4  destination register field.
REQ-008 ALUFlags  input  4  NZCV from the ALU this cycle.
REQ-009 IRWrite, AdrSrc, ALUSrcA  output  1 each  IR load, address-mux select (1 = ALUOut), ALU A select (1 = PC).
REQ-010 ALUSrcB  output  2  ALU B select: 00 reg, 01 imm, 10 const 4.
REQ-011 ResultSrc  output  2  result select: 00 ALUOut, 01 data read, 10 ALU result.
REQ-012 ImmSrc, RegSrc, ALUControl  output  2 each  imm extend type, register-read selects, ALU op (00 ADD, 01 SUB, 10 MOV).
REQ-013 PCWrite, RegWrite, MemWrite  output  1 each  write enables, condition-gated.
REQ-014 LinkWrite  output  1  write PC+4 to R14 (BL).
REQ-015 Flags  output  4  architectural NZCV register.
REQ-016 Illegal  output  1  one-cycle pulse on undecodable instruction.

Function
REQ-017 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
REQ-018 FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10, PCWrite=1 (unconditional); next DECODE.
REQ-019 DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=00 (PC+8 precompute); next by Op: 01->MEMADR, 00 & Funct[5]=1->EXECI, 00 & Funct[5]=0->EXECR, 10->BRANCH, 11->FETCH with Illegal=1.
REQ-020 MEMADR: ALUSrcB=01 (I=0) or 00 (I=1, register offset), ImmSrc=01, ALUControl=00 (U=1) or 01 (U=0); next MEMRD if Funct[0]=1, else MEMWR.
REQ-021 MEMRD: AdrSrc=1; next MEMWB.  MEMWB: ResultSrc=01, RegWrite=CondEx; next FETCH.
REQ-022 MEMWR: AdrSrc=1, RegSrc[1]=1, MemWrite=CondEx; next FETCH.
REQ-023 EXECR/EXECI: ALUSrcB=00/01, ImmSrc=00; ALUControl from cmd (0100 ADD, 0010 SUB, 1010 CMP->SUB, 1101 MOV); next ALUWB.
REQ-024 ALUWB: ResultSrc=00, RegWrite=CondEx & (cmd!=CMP); next FETCH.
REQ-025 Unsupported cmd in data-proc: no RegWrite, no flag update, Illegal=1 in ALUWB.
REQ-026 BRANCH: ALUSrcA=0, ALUSrcB=01, ImmSrc=10, RegSrc[0]=1, ResultSrc=10, PCWrite=CondEx, LinkWrite=CondEx & Funct[4]; next FETCH.
REQ-027 CondEx: combinational from Cond and registered Flags, full ARM table 0000-1110; 1111 = never.
REQ-028 Flags load ALUFlags at end of EXECR/EXECI iff CondEx & (Funct[0]=1 or cmd=CMP); otherwise hold.
REQ-029 Flag-update decision uses the pre-update Flags; a CMP followed by a conditional op uses the new Flags.
REQ-030 Latency: B/BL 3 cycles, STR and data-proc 4, LDR 5; failed condition does not shorten the sequence.
REQ-031 Outputs are Moore except CondEx-gated enables; all unlisted outputs are 0 in each state.
REQ-032 RegWrite, MemWrite and LinkWrite never assert in the same cycle as each other.

Reset
REQ-033 While reset=1: all write enables, IRWrite, Illegal = 0, state forced to FETCH at next edge, Flags = 0000.
REQ-034 Reset mid-instruction abandons the instruction; no partial write occurs in the reset cycle.

Structure
REQ-035 arm_ctrl_pkg holds the state enum, Op codes, cmd codes, ALUControl, ALUSrcB, ResultSrc and ImmSrc encodings.
REQ-036 Sub-module cond_check (Cond, Flags -> CondEx) is instantiated once.

Verification
REQ-037 ADDS R1,R2,#5, ALUFlags=0000 -> 4 cycles, RegWrite in ALUWB only, Flags=0000.
REQ-038 CMP with ALUFlags=0100, then ADDEQ -> Flags=0100, ADDEQ RegWrite=1; repeat with ADDNE -> RegWrite=0, 4 cycles.
REQ-039 LDR -> state sequence F,D,MEMADR,MEMRD,MEMWB, ResultSrc=01 in MEMWB; STRNE with Z=1 -> MemWrite never asserts.
REQ-040 BL AL -> PCWrite=1 and LinkWrite=1 in BRANCH; BEQ with Z=0 -> PCWrite=0 in BRANCH.
REQ-041 Op=11 -> Illegal pulse in DECODE, FETCH on the next cycle, no writes.
REQ-042 reset asserted in MEMWR -> MemWrite=0 that cycle, FETCH and Flags=0000 after the edge.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the ARM multicycle controller: FSM states, opcode classes,
// data-processing commands and datapath mux selects.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRd,
        StMemWb,
        StMemWr,
        StExecR,
        StExecI,
        StAluWb,
        StBranch
    } state_e;

    localparam logic [1:0] OpDp      = 2'b00;
    localparam logic [1:0] OpMem     = 2'b01;
    localparam logic [1:0] OpBranch  = 2'b10;
    localparam logic [1:0] OpIllegal = 2'b11;

    localparam logic [3:0] CmdAdd = 4'b0100;
    localparam logic [3:0] CmdSub = 4'b0010;
    localparam logic [3:0] CmdCmp = 4'b1010;
    localparam logic [3:0] CmdMov = 4'b1101;

    localparam logic [1:0] AluAdd = 2'b00;
    localparam logic [1:0] AluSub = 2'b01;
    localparam logic [1:0] AluMov = 2'b10;

    localparam logic [1:0] SrcBReg  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    localparam logic [1:0] ResAluOut = 2'b00;
    localparam logic [1:0] ResData   = 2'b01;
    localparam logic [1:0] ResAlu    = 2'b10;

    localparam logic [1:0] ImmDp  = 2'b00;
    localparam logic [1:0] ImmMem = 2'b01;
    localparam logic [1:0] ImmBr  = 2'b10;

    function automatic logic cmd_supported(input logic [3:0] cmd);
        return (cmd == CmdAdd) || (cmd == CmdSub) || (cmd == CmdCmp) || (cmd == CmdMov);
    endfunction

    function automatic logic [1:0] cmd_alu(input logic [3:0] cmd);
        case (cmd)
            CmdSub, CmdCmp: return AluSub;
            CmdMov:         return AluMov;
            default:        return AluAdd;
        endcase
    endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition-code evaluation: decides whether the held instruction executes
// given the architectural NZCV flags.
module cond_check (
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n, z, c, v;
    assign {n, z, c, v} = Flags;

    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            4'b0000: CondEx = z;
            4'b0001: CondEx = ~z;
            4'b0010: CondEx = c;
            4'b0011: CondEx = ~c;
            4'b0100: CondEx = n;
            4'b0101: CondEx = ~n;
            4'b0110: CondEx = v;
            4'b0111: CondEx = ~v;
            4'b1000: CondEx = c & ~z;
            4'b1001: CondEx = ~c | z;
            4'b1010: CondEx = (n == v);
            4'b1011: CondEx = (n != v);
            4'b1100: CondEx = ~z & (n == v);
            4'b1101: CondEx = z | (n != v);
            4'b1110: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM control unit: Moore FSM sequencing fetch/decode/execute, with
// condition-gated write enables and the architectural NZCV flag register.
module arm_multicycle_ctrl
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       LinkWrite,
    output logic [3:0] Flags,
    output logic       Illegal
);

    state_e     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       cond_ex;
    logic [3:0] cmd;
    logic       cmd_ok;

    assign cmd    = Funct[4:1];
    assign cmd_ok = cmd_supported(cmd);
    assign Flags  = flags_q;

    // Rd carries no control meaning in this instruction subset.
    logic unused_rd;
    assign unused_rd = ^Rd;

    cond_check u_cond_check (
        .Cond   (Cond),
        .Flags  (flags_q),
        .CondEx (cond_ex)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        flags_d    = flags_q;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SrcBReg;
        ResultSrc  = ResAluOut;
        ImmSrc     = ImmDp;
        RegSrc     = 2'b00;
        ALUControl = AluAdd;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        LinkWrite  = 1'b0;
        Illegal    = 1'b0;

        case (state_q)
            StFetch: begin
                IRWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SrcBFour;
                ResultSrc = ResAlu;
                PCWrite   = 1'b1;
                state_d   = StDecode;
            end
            StDecode: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SrcBFour;
                case (Op)
                    OpMem:    state_d = StMemAdr;
                    OpDp:     state_d = Funct[5] ? StExecI : StExecR;
                    OpBranch: state_d = StBranch;
                    default: begin
                        Illegal = 1'b1;
                        state_d = StFetch;
                    end
                endcase
            end
            StMemAdr: begin
                // Memory I-bit is inverted versus data-proc: I=1 means register offset.
                ALUSrcB    = Funct[5] ? SrcBReg : SrcBImm;
                ImmSrc     = ImmMem;
                ALUControl = Funct[3] ? AluAdd : AluSub;
                state_d    = Funct[0] ? StMemRd : StMemWr;
            end
            StMemRd: begin
                AdrSrc  = 1'b1;
                state_d = StMemWb;
            end
            StMemWb: begin
                ResultSrc = ResData;
                RegWrite  = cond_ex;
                state_d   = StFetch;
            end
            StMemWr: begin
                AdrSrc   = 1'b1;
                RegSrc   = 2'b10;
                MemWrite = cond_ex;
                state_d  = StFetch;
            end
            StExecR, StExecI: begin
                ALUSrcB    = (state_q == StExecI) ? SrcBImm : SrcBReg;
                ImmSrc     = ImmDp;
                ALUControl = cmd_alu(cmd);
                if (cond_ex && cmd_ok && (Funct[0] || cmd == CmdCmp)) begin
                    flags_d = ALUFlags;
                end
                state_d = StAluWb;
            end
            StAluWb: begin
                ResultSrc = ResAluOut;
                RegWrite  = cond_ex & cmd_ok & (cmd != CmdCmp);
                Illegal   = ~cmd_ok;
                state_d   = StFetch;
            end
            StBranch: begin
                ALUSrcB   = SrcBImm;
                ImmSrc    = ImmBr;
                RegSrc    = 2'b01;
                ResultSrc = ResAlu;
                PCWrite   = cond_ex;
                LinkWrite = cond_ex & Funct[4];
                state_d   = StFetch;
            end
            default: state_d = StFetch;
        endcase

        // Reset abandons the instruction: nothing may be written in this cycle.
        if (reset) begin
            IRWrite   = 1'b0;
            PCWrite   = 1'b0;
            RegWrite  = 1'b0;
            MemWrite  = 1'b0;
            LinkWrite = 1'b0;
            Illegal   = 1'b0;
        end
    end

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Directed bench for arm_multicycle_ctrl: walks each instruction class cycle by
// cycle and compares the full control vector against hand-derived values.
module tb_arm_multicycle_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       IRWrite, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
    logic       PCWrite, RegWrite, MemWrite, LinkWrite;
    logic [3:0] Flags;
    logic       Illegal;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    arm_multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .Cond       (Cond),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .ALUFlags   (ALUFlags),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .LinkWrite  (LinkWrite),
        .Flags      (Flags),
        .Illegal    (Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [17:0] outs;
    assign outs = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl,
                   PCWrite, RegWrite, MemWrite, LinkWrite, Illegal};

    function automatic logic [17:0] pk(input logic ir, input logic adr, input logic sa,
                                       input logic [1:0] sb, input logic [1:0] rs,
                                       input logic [1:0] imm, input logic [1:0] rg,
                                       input logic [1:0] alu, input logic pcw,
                                       input logic rw, input logic mw, input logic lw,
                                       input logic ill);
        return {ir, adr, sa, sb, rs, imm, rg, alu, pcw, rw, mw, lw, ill};
    endfunction

    function automatic logic [17:0] e_fetch();
        return pk(1, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0);
    endfunction
    function automatic logic [17:0] e_decode(input logic ill);
        return pk(0, 0, 1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, ill);
    endfunction
    function automatic logic [17:0] e_memadr(input logic [1:0] sb, input logic [1:0] alu);
        return pk(0, 0, 0, sb, 2'b00, 2'b01, 2'b00, alu, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [17:0] e_memrd();
        return pk(0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [17:0] e_memwb(input logic rw);
        return pk(0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 0, rw, 0, 0, 0);
    endfunction
    function automatic logic [17:0] e_memwr(input logic mw);
        return pk(0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 0, 0, mw, 0, 0);
    endfunction
    function automatic logic [17:0] e_exec(input logic [1:0] sb, input logic [1:0] alu);
        return pk(0, 0, 0, sb, 2'b00, 2'b00, 2'b00, alu, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [17:0] e_aluwb(input logic rw, input logic ill);
        return pk(0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, rw, 0, 0, ill);
    endfunction
    function automatic logic [17:0] e_branch(input logic pcw, input logic lw);
        return pk(0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00, pcw, 0, 0, lw, 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic step(input string tag, input logic [17:0] exp);
        tick();
        chk(tag, {14'd0, outs}, {14'd0, exp});
    endtask

    // Presents a new instruction and checks that it starts in FETCH.
    task automatic issue(input string tag, input logic [3:0] c, input logic [1:0] op,
                         input logic [5:0] f, input logic [3:0] af);
        if (started) tick();
        started  = 1;
        Cond     = c;
        Op       = op;
        Funct    = f;
        ALUFlags = af;
        Rd       = 4'd1;
        #1;
        chk({tag, "_fetch"}, {14'd0, outs}, {14'd0, e_fetch()});
    endtask

    initial begin
        reset    = 1'b1;
        Cond     = 4'b1110;
        Op       = 2'b00;
        Funct    = 6'b000000;
        Rd       = 4'd0;
        ALUFlags = 4'b1111;
        #1;
        chk("rst_enables", {26'd0, IRWrite, PCWrite, RegWrite, MemWrite, LinkWrite, Illegal},
            32'd0);
        tick();
        chk("rst_flags", {28'd0, Flags}, 32'd0);
        reset = 1'b0;

        // ADDS R1,R2,#5
        issue("adds", 4'b1110, 2'b00, 6'b101001, 4'b0000);
        step("adds_decode", e_decode(0));
        step("adds_execi", e_exec(2'b01, 2'b00));
        step("adds_aluwb", e_aluwb(1, 0));
        chk("adds_flags", {28'd0, Flags}, 32'h0);

        // CMP sets Z, then ADDEQ executes and ADDNE does not
        issue("cmp", 4'b1110, 2'b00, 6'b010101, 4'b0100);
        step("cmp_decode", e_decode(0));
        step("cmp_execr", e_exec(2'b00, 2'b01));
        step("cmp_aluwb", e_aluwb(0, 0));
        chk("cmp_flags", {28'd0, Flags}, 32'h4);

        issue("addeq", 4'b0000, 2'b00, 6'b001000, 4'b1111);
        step("addeq_decode", e_decode(0));
        step("addeq_execr", e_exec(2'b00, 2'b00));
        step("addeq_aluwb", e_aluwb(1, 0));
        chk("addeq_flags", {28'd0, Flags}, 32'h4);

        issue("addne", 4'b0001, 2'b00, 6'b001000, 4'b1111);
        step("addne_decode", e_decode(0));
        step("addne_execr", e_exec(2'b00, 2'b00));
        step("addne_aluwb", e_aluwb(0, 0));

        // LDR R0,[R1,#imm] with U=1
        issue("ldr", 4'b1110, 2'b01, 6'b011001, 4'b0000);
        step("ldr_decode", e_decode(0));
        step("ldr_memadr", e_memadr(2'b01, 2'b00));
        step("ldr_memrd", e_memrd());
        step("ldr_memwb", e_memwb(1));

        // STRNE, register offset, U=0, with Z=1
        issue("strne", 4'b0001, 2'b01, 6'b110000, 4'b0000);
        step("strne_decode", e_decode(0));
        step("strne_memadr", e_memadr(2'b00, 2'b01));
        step("strne_memwr", e_memwr(0));

        // BL always
        issue("bl", 4'b1110, 2'b10, 6'b110000, 4'b0000);
        step("bl_decode", e_decode(0));
        step("bl_branch", e_branch(1, 1));

        // MOVS immediate clears Z so that BEQ falls through
        issue("movs", 4'b1110, 2'b00, 6'b111011, 4'b0010);
        step("movs_decode", e_decode(0));
        step("movs_execi", e_exec(2'b01, 2'b10));
        step("movs_aluwb", e_aluwb(1, 0));
        chk("movs_flags", {28'd0, Flags}, 32'h2);

        issue("beq", 4'b0000, 2'b10, 6'b100000, 4'b0000);
        step("beq_decode", e_decode(0));
        step("beq_branch", e_branch(0, 0));

        // Op=11 is illegal: pulse in DECODE, straight back to FETCH
        issue("ill", 4'b1110, 2'b11, 6'b000000, 4'b0000);
        step("ill_decode", e_decode(1));

        // Unsupported data-proc cmd (AND) with S=1: no write, no flag change
        issue("and", 4'b1110, 2'b00, 6'b000001, 4'b1111);
        step("and_decode", e_decode(0));
        step("and_execr", e_exec(2'b00, 2'b00));
        step("and_aluwb", e_aluwb(0, 1));
        chk("and_flags", {28'd0, Flags}, 32'h2);

        // STR interrupted by reset in MEMWR
        issue("str", 4'b1110, 2'b01, 6'b011000, 4'b0000);
        step("str_decode", e_decode(0));
        step("str_memadr", e_memadr(2'b01, 2'b00));
        step("str_memwr", e_memwr(1));
        reset = 1'b1;
        #1;
        chk("str_rst_memwrite", {31'd0, MemWrite}, 32'd0);
        tick();
        chk("str_rst_flags", {28'd0, Flags}, 32'd0);
        reset = 1'b0;
        #1;
        chk("str_rst_fetch", {14'd0, outs}, {14'd0, e_fetch()});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
